// File: rtl/pushsw_updown_counter.sv
// pushsw_updown_counter: debounced up/down/clear push switches driving a bounded counter
// with hold-to-auto-repeat and selectable wrap or saturate at the limits.
module pushsw_updown_counter #(
    parameter int CNT_W       = 10,
    parameter int MAX_VAL     = 255,
    parameter int TICK_DIV    = 3000000,
    parameter int PRE_W       = 22,
    parameter int WRAP        = 1,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10,
    parameter int HOLD_W      = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [2:0]       PUSH,
    output logic [CNT_W-1:0] COUNT,
    output logic             STEP,
    output logic             WRAPPED,
    output logic             AT_LIMIT
);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV);
    localparam logic [CNT_W-1:0]  MAX       = CNT_W'(MAX_VAL);
    localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(REPEAT_DLY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST = HOLD_W'(REPEAT_RATE - 1);
    localparam logic              WRAP_EN   = WRAP != 0;

    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [2:0]        samp0_q, samp0_d, samp1_q, samp1_d, arm_q, arm_d, rise;
    state_t            st_q [2];
    state_t            st_d [2];
    logic [HOLD_W-1:0] hc_q [2];
    logic [HOLD_W-1:0] hc_d [2];
    logic [1:0]        req;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_q, step_d, wrap_q, wrap_d;
    logic              tick, clr, up_only, dn_only, at_max, at_zero;

    always_comb begin
        tick    = pre_q == PRE_LAST;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        samp0_d = tick ? PUSH : samp0_q;
        samp1_d = tick ? samp0_q : samp1_q;
        // a button held through reset must be seen released before its next press counts
        arm_d   = tick ? (arm_q | ~PUSH) : arm_q;
        rise    = samp0_q & ~samp1_q & arm_q;
        clr     = tick & rise[2];
        for (int i = 0; i < 2; i++) begin
            st_d[i] = st_q[i];
            hc_d[i] = hc_q[i];
            req[i]  = 1'b0;
            if (tick) begin
                case (st_q[i])
                    IDLE: if (rise[i]) begin
                        req[i]  = 1'b1;
                        st_d[i] = HOLD;
                        hc_d[i] = '0;
                    end
                    HOLD: if (!samp0_q[i]) st_d[i] = IDLE;
                    else if (hc_q[i] == DLY_LAST) begin
                        req[i]  = 1'b1;
                        st_d[i] = RPT;
                        hc_d[i] = '0;
                    end else hc_d[i] = hc_q[i] + 1'b1;
                    RPT: if (!samp0_q[i]) st_d[i] = IDLE;
                    else if (hc_q[i] == RATE_LAST) begin
                        req[i]  = 1'b1;
                        hc_d[i] = '0;
                    end else hc_d[i] = hc_q[i] + 1'b1;
                    default: st_d[i] = IDLE;
                endcase
                if (rise[2]) st_d[i] = IDLE;
            end
        end
        up_only = req[1] & ~req[0];
        dn_only = req[0] & ~req[1];
        at_max  = cnt_q == MAX;
        at_zero = cnt_q == '0;
        cnt_d   = clr     ? '0 :
                  up_only ? (at_max ? (WRAP_EN ? '0 : cnt_q) : cnt_q + 1'b1) :
                  dn_only ? (at_zero ? (WRAP_EN ? MAX : cnt_q) : cnt_q - 1'b1) : cnt_q;
        wrap_d  = !clr && WRAP_EN && ((up_only && at_max) || (dn_only && at_zero));
        step_d  = cnt_d != cnt_q;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_q   <= '0;
            samp0_q <= '0;
            samp1_q <= '0;
            arm_q   <= '0;
            st_q    <= '{default: IDLE};
            hc_q    <= '{default: '0};
            cnt_q   <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
            arm_q   <= arm_d;
            st_q    <= st_d;
            hc_q    <= hc_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

    assign COUNT    = cnt_q;
    assign STEP     = step_q;
    assign WRAPPED  = wrap_q;
    assign AT_LIMIT = (cnt_q == '0) || (cnt_q == MAX);
endmodule

// File: tb/tb_pushsw_updown_counter.sv
// tb_pushsw_updown_counter: scoreboard bench, one wrapping and one saturating counter,
// four-clock ticks, PUSH changed right after a tick and results read just after the next tick edge.
module tb_pushsw_updown_counter;
    typedef struct packed {
        logic [2:0] p;
        logic [9:0] cnt;
        logic       st;
        logic       wr;
    } row_t;
    typedef struct packed {
        logic [9:0] cnt;
        logic       st;
        logic       wr;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [2:0] PUSH = '0;
    logic [2:0] push_s = '0;
    logic [9:0] COUNT, count_s;
    logic       STEP, WRAPPED, AT_LIMIT, step_s, wrap_s, lim_s;
    logic [12:0] obs_m, obs_s;
    logic [1:0]  late_m, late_s;
    exp_t        sb [$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;

    pushsw_updown_counter #(.CNT_W(10), .MAX_VAL(9), .TICK_DIV(3), .PRE_W(2), .WRAP(1),
        .REPEAT_DLY(4), .REPEAT_RATE(2), .HOLD_W(3)) dut (
        .CLK(CLK), .RSTn(RSTn), .PUSH(PUSH), .COUNT(COUNT), .STEP(STEP),
        .WRAPPED(WRAPPED), .AT_LIMIT(AT_LIMIT));

    pushsw_updown_counter #(.CNT_W(10), .MAX_VAL(9), .TICK_DIV(3), .PRE_W(2), .WRAP(0),
        .REPEAT_DLY(4), .REPEAT_RATE(2), .HOLD_W(3)) dut_sat (
        .CLK(CLK), .RSTn(RSTn), .PUSH(push_s), .COUNT(count_s), .STEP(step_s),
        .WRAPPED(wrap_s), .AT_LIMIT(lim_s));

    always #5 CLK = ~CLK;

    function automatic row_t r(input int p, input int c, input int s, input int w);
        return row_t'{p[2:0], c[9:0], s[0], w[0]};
    endfunction

    function automatic logic lim(input logic [9:0] c);
        return (c == 10'd0) || (c == 10'd9);
    endfunction

    // Starts one clock after a tick edge; ends one clock after the next tick edge.
    task automatic advance(input logic [2:0] p, input logic [2:0] ps);
        PUSH = p;
        push_s = ps;
        repeat (3) @(posedge CLK);
        #1;
        obs_m = {COUNT, STEP, WRAPPED, AT_LIMIT};
        obs_s = {count_s, step_s, wrap_s, lim_s};
        @(posedge CLK);
        #1;
        late_m = {STEP, WRAPPED};
        late_s = {step_s, wrap_s};
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if ({COUNT, STEP, WRAPPED, AT_LIMIT, count_s, lim_s} !== {10'd0, 3'b001, 10'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset: cnt=%0d step=%b wrap=%b lim=%b sat_cnt=%0d, want 0/0/0/1 sat 0",
                     COUNT, STEP, WRAPPED, AT_LIMIT, count_s);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_main_rows(input string name, input row_t t [], input int n);
    endtask

    task automatic test_single_tap();
        row_t t [11];
        t = '{r(0,0,0,0), r(0,0,0,0), r(2,0,0,0), r(2,1,1,0), r(0,1,0,0), r(0,1,0,0),
              r(0,1,0,0), r(4,1,0,0), r(4,0,1,0), r(0,0,0,0), r(0,0,0,0)};
        for (int i = 0; i < 11; i++) begin
            sb.push_back(exp_t'{t[i].cnt, t[i].st, t[i].wr});
            advance(t[i].p, 3'b000);
            e = sb.pop_front();
            vectors++;
            if (obs_m !== {e.cnt, e.st, e.wr, lim(e.cnt)}) begin
                miscompares++;
                $display("FAIL tap[%0d]: cnt/step/wrap/lim got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_m[12:3], obs_m[2], obs_m[1], obs_m[0], e.cnt, e.st, e.wr, lim(e.cnt));
            end
            vectors++;
            if (late_m !== 2'b00) begin
                miscompares++;
                $display("FAIL tap[%0d] pulse width: step/wrap=%b want 00", i, late_m);
            end
        end
    endtask

    task automatic test_hold_repeat();
        row_t t [13];
        t = '{r(2,0,0,0), r(2,1,1,0), r(2,1,0,0), r(2,1,0,0), r(2,1,0,0), r(2,2,1,0), r(2,2,0,0),
              r(2,3,1,0), r(2,3,0,0), r(2,4,1,0), r(0,4,0,0), r(0,4,0,0), r(0,4,0,0)};
        for (int i = 0; i < 13; i++) begin
            sb.push_back(exp_t'{t[i].cnt, t[i].st, t[i].wr});
            advance(t[i].p, 3'b000);
            e = sb.pop_front();
            vectors++;
            if (obs_m !== {e.cnt, e.st, e.wr, lim(e.cnt)}) begin
                miscompares++;
                $display("FAIL hold[%0d]: cnt/step/wrap/lim got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_m[12:3], obs_m[2], obs_m[1], obs_m[0], e.cnt, e.st, e.wr, lim(e.cnt));
            end
            vectors++;
            if (late_m !== 2'b00) begin
                miscompares++;
                $display("FAIL hold[%0d] pulse width: step/wrap=%b want 00", i, late_m);
            end
        end
    endtask

    task automatic test_wrap();
        row_t t [16];
        t = '{r(4,4,0,0), r(4,0,1,0), r(0,0,0,0), r(0,0,0,0), r(1,0,0,0), r(1,9,1,1),
              r(0,9,0,0), r(0,9,0,0), r(2,9,0,0), r(2,0,1,1), r(0,0,0,0), r(0,0,0,0),
              r(1,0,0,0), r(1,9,1,1), r(0,9,0,0), r(0,9,0,0)};
        for (int i = 0; i < 16; i++) begin
            sb.push_back(exp_t'{t[i].cnt, t[i].st, t[i].wr});
            advance(t[i].p, 3'b000);
            e = sb.pop_front();
            vectors++;
            if (obs_m !== {e.cnt, e.st, e.wr, lim(e.cnt)}) begin
                miscompares++;
                $display("FAIL wrap[%0d]: cnt/step/wrap/lim got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_m[12:3], obs_m[2], obs_m[1], obs_m[0], e.cnt, e.st, e.wr, lim(e.cnt));
            end
            vectors++;
            if (late_m !== 2'b00) begin
                miscompares++;
                $display("FAIL wrap[%0d] pulse width: step/wrap=%b want 00", i, late_m);
            end
        end
    endtask

    // Saturating instance: down tap at 0, then hold up from 0 past 9 for 20+ ticks, then release.
    task automatic test_saturate();
        int         h, c;
        logic       s;
        logic [2:0] ps;
        for (int i = 0; i < 46; i++) begin
            h  = i - 3;
            ps = (i < 2) ? 3'b001 : (i < 4 || i >= 44) ? 3'b000 : 3'b010;
            c  = (i < 4) ? 0 : (i >= 44) ? 9 : (h < 2) ? 0 : (h < 6) ? 1 :
                 ((2 + (h - 6) / 2) > 9) ? 9 : 2 + (h - 6) / 2;
            s  = (i >= 4) && (i < 44) && ((h == 2) || (h >= 6 && h <= 20 && h % 2 == 0));
            sb.push_back(exp_t'{c[9:0], s, 1'b0});
            advance(3'b000, ps);
            e = sb.pop_front();
            vectors++;
            if (obs_s !== {e.cnt, e.st, e.wr, lim(e.cnt)}) begin
                miscompares++;
                $display("FAIL sat[%0d]: cnt/step/wrap/lim got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_s[12:3], obs_s[2], obs_s[1], obs_s[0], e.cnt, e.st, e.wr, lim(e.cnt));
            end
            vectors++;
            if (late_s !== 2'b00) begin
                miscompares++;
                $display("FAIL sat[%0d] pulse width: step/wrap=%b want 00", i, late_s);
            end
        end
    endtask

    task automatic test_conflicts();
        row_t t [35];
        t = '{r(1,9,0,0), r(1,8,1,0), r(1,8,0,0), r(1,8,0,0), r(1,8,0,0), r(1,7,1,0), r(1,7,0,0),
              r(1,6,1,0), r(1,6,0,0), r(1,5,1,0), r(0,5,0,0), r(0,5,0,0),
              r(3,5,0,0), r(3,5,0,0), r(0,5,0,0), r(0,5,0,0),
              r(2,5,0,0), r(2,6,1,0), r(2,6,0,0), r(2,6,0,0), r(2,6,0,0), r(2,7,1,0),
              r(6,7,0,0), r(6,0,1,0),
              r(2,0,0,0), r(2,0,0,0), r(2,0,0,0), r(2,0,0,0), r(2,0,0,0), r(2,0,0,0),
              r(0,0,0,0), r(2,0,0,0), r(2,1,1,0), r(0,1,0,0), r(0,1,0,0)};
        for (int i = 0; i < 35; i++) begin
            sb.push_back(exp_t'{t[i].cnt, t[i].st, t[i].wr});
            advance(t[i].p, 3'b000);
            e = sb.pop_front();
            vectors++;
            if (obs_m !== {e.cnt, e.st, e.wr, lim(e.cnt)}) begin
                miscompares++;
                $display("FAIL conflict[%0d]: cnt/step/wrap/lim got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_m[12:3], obs_m[2], obs_m[1], obs_m[0], e.cnt, e.st, e.wr, lim(e.cnt));
            end
            vectors++;
            if (late_m !== 2'b00) begin
                miscompares++;
                $display("FAIL conflict[%0d] pulse width: step/wrap=%b want 00", i, late_m);
            end
        end
    endtask

    // Reset asserted mid-repeat at 6, released with up still held; rows 12.. follow the release.
    task automatic test_reset_mid_hold();
        row_t t [21];
        t = '{r(2,1,0,0), r(2,2,1,0), r(2,2,0,0), r(2,2,0,0), r(2,2,0,0), r(2,3,1,0), r(2,3,0,0),
              r(2,4,1,0), r(2,4,0,0), r(2,5,1,0), r(2,5,0,0), r(2,6,1,0),
              r(2,0,0,0), r(2,0,0,0), r(2,0,0,0), r(2,0,0,0), r(0,0,0,0), r(2,0,0,0),
              r(2,1,1,0), r(0,1,0,0), r(0,1,0,0)};
        for (int i = 0; i < 21; i++) begin
            if (i == 12) begin
                #2;
                RSTn = 1'b0;
                #1;
                vectors++;
                if ({COUNT, STEP, WRAPPED, AT_LIMIT, count_s} !== {10'd0, 3'b001, 10'd0}) begin
                    miscompares++;
                    $display("FAIL async reset: cnt=%0d step=%b wrap=%b lim=%b sat_cnt=%0d, want 0/0/0/1 sat 0",
                             COUNT, STEP, WRAPPED, AT_LIMIT, count_s);
                end
                repeat (2) @(negedge CLK);
                RSTn = 1'b1;
                @(posedge CLK);
                #1;
            end
            sb.push_back(exp_t'{t[i].cnt, t[i].st, t[i].wr});
            advance(t[i].p, 3'b000);
            e = sb.pop_front();
            vectors++;
            if (obs_m !== {e.cnt, e.st, e.wr, lim(e.cnt)}) begin
                miscompares++;
                $display("FAIL rst_hold[%0d]: cnt/step/wrap/lim got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_m[12:3], obs_m[2], obs_m[1], obs_m[0], e.cnt, e.st, e.wr, lim(e.cnt));
            end
            vectors++;
            if (late_m !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_hold[%0d] pulse width: step/wrap=%b want 00", i, late_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_hold_repeat();
        test_wrap();
        test_saturate();
        test_conflicts();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
